// File: rtl/std_div_seq.sv
// std_div_seq: multi-cycle unsigned restoring divider, one quotient bit per cycle.
// Quotient and remainder are produced together and held until the next
// operation completes. Fixed latency: done is high WIDTH+1 cycles after go
// is accepted.
// Optional feature macro: STD_DIV_SEQ_ZERO_FLAG_EN adds a registered
// div_by_zero output that is valid whenever done=1.
//
// Handshake: go is sampled only while the FSM is in IDLE; an accepted go
// captures left/right, and later changes to either operand or to go have no
// effect until the FSM returns to IDLE. done is a one-cycle pulse marking
// out_quotient/out_remainder as newly updated. go may be held high through
// done, in which case IDLE accepts it the cycle after done.
module std_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             done,
`ifdef STD_DIV_SEQ_ZERO_FLAG_EN
  output logic             div_by_zero,
`endif
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] divisor, divisor_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [WIDTH-1:0] quo, quo_n;
  logic [WIDTH-1:0] res_q, res_q_n;
  logic [WIDTH-1:0] res_r, res_r_n;

  // Trial subtraction is one bit wider than the operands so that a partial
  // remainder shifted past bit WIDTH-1 still compares correctly against
  // divisors with their MSB set.
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             fits;

`ifdef STD_DIV_SEQ_ZERO_FLAG_EN
  logic             dbz, dbz_n;
`endif

  // Datapath for one restoring step, evaluated every cycle.
  always_comb begin
    shifted = {acc, quo[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    fits    = (shifted >= {1'b0, divisor});
  end

  // Next-state and next-datapath values; every target defaults to a hold.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    divisor_n = divisor;
    acc_n     = acc;
    quo_n     = quo;
    res_q_n   = res_q;
    res_r_n   = res_r;
`ifdef STD_DIV_SEQ_ZERO_FLAG_EN
    dbz_n     = dbz;
`endif
    case (state)
      IDLE: begin
        if (go) begin
          divisor_n = right;
          acc_n     = '0;
          quo_n     = left;
          cnt_n     = '0;
          state_n   = BUSY;
        end
      end
      BUSY: begin
        acc_n = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_n = {quo[WIDTH-2:0], fits};
        cnt_n = cnt + 1'b1;
        // The step taken with cnt at its last value produces the final
        // quotient bit, so results are loaded on this same edge.
        if (cnt == LAST_CNT) begin
          state_n = DONE;
          res_q_n = quo_n;
          res_r_n = acc_n;
`ifdef STD_DIV_SEQ_ZERO_FLAG_EN
          dbz_n   = (divisor == '0);
`endif
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      divisor <= '0;
      acc     <= '0;
      quo     <= '0;
      res_q   <= '0;
      res_r   <= '0;
`ifdef STD_DIV_SEQ_ZERO_FLAG_EN
      dbz     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      divisor <= divisor_n;
      acc     <= acc_n;
      quo     <= quo_n;
      res_q   <= res_q_n;
      res_r   <= res_r_n;
`ifdef STD_DIV_SEQ_ZERO_FLAG_EN
      dbz     <= dbz_n;
`endif
    end
  end

  // Output decode: done is the DONE state itself, so it lasts one cycle.
  always_comb begin
    out_quotient  = res_q;
    out_remainder = res_r;
    done          = (state == DONE);
    state_dbg     = state;
`ifdef STD_DIV_SEQ_ZERO_FLAG_EN
    div_by_zero   = dbz;
`endif
  end

`ifdef STD_DIV_SEQ_ZERO_FLAG_EN
  // Flag a zero divisor at the moment the operation is accepted.
  always @(posedge clk) begin
    if (!reset && state == IDLE && go && right == '0)
      $error("std_div_seq: go accepted with right == 0");
  end
`endif

endmodule
